// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the core's instruction port (A, read-only) and data port
// (B, read/write) onto one downstream memory port. The winning request is
// latched for the whole transaction and each served request gets exactly
// one single-cycle response pulse.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     : contention goes to the port not served last; the pointer
//                 updates on each DONE and resets to "last served = A".
//   not defined : fixed priority, port B always wins contention.
//
// States:
//   IDLE   | sample requests, grant one port
//   BUSY_A | port A read in flight downstream
//   BUSY_B | port B read or write in flight downstream
//   DONE   | one-cycle response to the served port, requests not sampled

module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        read_a,
    input  logic [31:0] address_a,
    output logic        resp_a,
    output logic [31:0] rdata_a,

    input  logic        read_b,
    input  logic        write,
    input  logic [3:0]  wmask,
    input  logic [31:0] address_b,
    input  logic [31:0] wdata,
    output logic        resp_b,
    output logic [31:0] rdata_b,

    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Request registers: the only source of the downstream port.
    logic [31:0] req_addr_q,  req_addr_d;
    logic        req_write_q, req_write_d;
    logic [3:0]  req_mask_q,  req_mask_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    // Port owning the current (or just finished) transaction: 1 = B.
    logic        served_b_q,  served_b_d;

    logic [31:0] rdata_a_q,   rdata_a_d;
    logic [31:0] rdata_b_q,   rdata_b_d;

    logic        pend_a;
    logic        pend_b;
    logic        grant_a;
    logic        grant_b;
    logic        busy;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = port B was served last; reset value means "last served = A".
    logic        last_b_q, last_b_d;
`endif

    // Pending requests and the grant decision for the IDLE state.
    always_comb begin
        pend_a = read_a;
        pend_b = read_b | write;
`ifdef ARB_ROUND_ROBIN_EN
        grant_b = pend_b & (~pend_a | ~last_b_q);
`else
        grant_b = pend_b;
`endif
        grant_a = pend_a & ~grant_b;
    end

    // Next-state logic, request latching and read-data capture.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_mask_d  = req_mask_q;
        req_wdata_d = req_wdata_q;
        served_b_d  = served_b_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_b_d    = last_b_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (grant_b) begin
                    state_d     = BUSY_B;
                    req_addr_d  = address_b;
                    // A simultaneous read_b and write is treated as a write.
                    req_write_d = write;
                    req_mask_d  = wmask;
                    req_wdata_d = wdata;
                    served_b_d  = 1'b1;
                end else if (grant_a) begin
                    state_d     = BUSY_A;
                    req_addr_d  = address_a;
                    req_write_d = 1'b0;
                    req_mask_d  = 4'b0000;
                    req_wdata_d = 32'h0000_0000;
                    served_b_d  = 1'b0;
                end
            end

            BUSY_A, BUSY_B: begin
                if (mem_resp) begin
                    state_d = DONE;
                    if (!req_write_q) begin
                        if (served_b_q) begin
                            rdata_b_d = mem_rdata;
                        end else begin
                            rdata_a_d = mem_rdata;
                        end
                    end
                end
            end

            DONE: begin
                // Requests are deliberately not looked at here so a request
                // still held during its response cycle cannot be re-granted.
                state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                last_b_d = served_b_q;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_addr_q  <= 32'h0000_0000;
            req_write_q <= 1'b0;
            req_mask_q  <= 4'b0000;
            req_wdata_q <= 32'h0000_0000;
            served_b_q  <= 1'b0;
            rdata_a_q   <= 32'h0000_0000;
            rdata_b_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_mask_q  <= req_mask_d;
            req_wdata_q <= req_wdata_d;
            served_b_q  <= served_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b0;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    // Outputs decoded from state and request registers only; no path from
    // requester inputs reaches the downstream port.
    always_comb begin
        busy        = (state_q == BUSY_A) || (state_q == BUSY_B);
        mem_read    = busy & ~req_write_q;
        mem_write   = busy &  req_write_q;
        mem_wmask   = req_mask_q;
        mem_address = req_addr_q;
        mem_wdata   = req_wdata_q;
        resp_a      = (state_q == DONE) & ~served_b_q;
        resp_b      = (state_q == DONE) &  served_b_q;
        rdata_a     = rdata_a_q;
        rdata_b     = rdata_b_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model (pending flags, a "last served" bit and per-port read-data values)
// predicts the winner, downstream values and responses of every request.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_a;
    logic [31:0] address_a;
    logic        resp_a;
    logic [31:0] rdata_a;
    logic        read_b;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address_b;
    logic [31:0] wdata;
    logic        resp_b;
    logic [31:0] rdata_b;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_last_b;
    logic [31:0] m_rdata_a;
    logic [31:0] m_rdata_b;
    bit          order [4];
    bit          exp_order [4];

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .read_a      (read_a),
        .address_a   (address_a),
        .resp_a      (resp_a),
        .rdata_a     (rdata_a),
        .read_b      (read_b),
        .write       (write),
        .wmask       (wmask),
        .address_b   (address_b),
        .wdata       (wdata),
        .resp_b      (resp_b),
        .rdata_b     (rdata_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".resp_a"},      {31'd0, resp_a},    32'd0);
        chk({tag, ".resp_b"},      {31'd0, resp_b},    32'd0);
        chk({tag, ".rdata_a"},     rdata_a,            32'd0);
        chk({tag, ".rdata_b"},     rdata_b,            32'd0);
        chk({tag, ".mem_read"},    {31'd0, mem_read},  32'd0);
        chk({tag, ".mem_write"},   {31'd0, mem_write}, 32'd0);
        chk({tag, ".mem_wmask"},   {28'd0, mem_wmask}, 32'd0);
        chk({tag, ".mem_address"}, mem_address,        32'd0);
        chk({tag, ".mem_wdata"},   mem_wdata,          32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, ".resps"},   {30'd0, resp_a, resp_b},      32'd0);
        chk({tag, ".rdata_a"}, rdata_a, m_rdata_a);
        chk({tag, ".rdata_b"}, rdata_b, m_rdata_b);
    endtask

    task automatic model_reset;
        m_last_b  = 1'b0;
        m_rdata_a = 32'd0;
        m_rdata_b = 32'd0;
    endtask

    // Serve one request starting from an IDLE cycle with requests driven.
    // lat = BUSY cycles before mem_resp is seen (mem_resp in the lat-th one).
    task automatic serve(input int lat, input logic [31:0] rd, input bit keep,
                         input bit inject, output bit won_b);
        bit          pa, pb;
        logic        e_wr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mask;
        pa = read_a;
        pb = read_b | write;
`ifdef ARB_ROUND_ROBIN_EN
        won_b = pb && (!pa || !m_last_b);
`else
        won_b = pb;
`endif
        if (won_b) begin
            e_addr = address_b; e_wr = write; e_mask = wmask; e_wdata = wdata;
        end else begin
            e_addr = address_a; e_wr = 1'b0; e_mask = 4'd0; e_wdata = 32'd0;
        end
        tick;
        for (int c = 1; c <= lat; c++) begin
            chk("busy.mem_read",    {31'd0, mem_read},  {31'd0, ~e_wr});
            chk("busy.mem_write",   {31'd0, mem_write}, {31'd0, e_wr});
            chk("busy.mem_address", mem_address, e_addr);
            chk("busy.mem_wmask",   {28'd0, mem_wmask}, {28'd0, e_mask});
            if (e_wr) chk("busy.mem_wdata", mem_wdata, e_wdata);
            chk("busy.resps", {30'd0, resp_a, resp_b}, 32'd0);
            if (inject && c == 1) begin
                address_a = 32'h0000_0200;
                write     = 1'b1;
                address_b = 32'h0000_0abc;
                wdata     = 32'h1357_9bdf;
                wmask     = 4'b1111;
            end else if (!inject) begin
                if (won_b) begin
                    address_b = $urandom; wdata = $urandom; wmask = 4'($urandom);
                end else begin
                    address_a = $urandom;
                end
            end
            mem_resp  = (c == lat);
            mem_rdata = (c == lat) ? rd : $urandom;
            tick;
        end
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        if (!e_wr) begin
            if (won_b) m_rdata_b = rd;
            else       m_rdata_a = rd;
        end
        chk("done.resp_a",  {31'd0, resp_a}, {31'd0, ~won_b});
        chk("done.resp_b",  {31'd0, resp_b}, {31'd0, won_b});
        chk("done.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("done.rdata_a", rdata_a, m_rdata_a);
        chk("done.rdata_b", rdata_b, m_rdata_b);
        m_last_b = won_b;
        tick;
        // The request stayed high through the response cycle; drop it now.
        if (!keep) begin
            if (won_b) begin read_b = 1'b0; write = 1'b0; end
            else       read_a = 1'b0;
        end
        chk_quiet("after_done");
    endtask

    initial begin
        bit wb;
        rst = 1'b1;
        read_a = 0; address_a = 0; read_b = 0; write = 0; wmask = 0;
        address_b = 0; wdata = 0; mem_resp = 0; mem_rdata = 0;
        model_reset();
        tick;
        tick;
        chk_all_zero("reset");
        rst = 1'b0;

        // Lone A read, three BUSY cycles, then one check that it is not re-served.
        read_a = 1'b1; address_a = 32'h0000_0060;
        serve(3, 32'h0000_0513, 1'b0, 1'b0, wb);
        chk("lone_a.winner", {31'd0, wb}, 32'd0);
        tick;
        chk_quiet("no_second_a");

        // Masked B write with one-cycle memory latency.
        write = 1'b1; address_b = 32'h0000_0100; wdata = 32'hdead_beef; wmask = 4'b0011;
        serve(1, 32'hffff_ffff, 1'b0, 1'b0, wb);
        chk("b_write.rdata_b", rdata_b, 32'd0);

        // Inputs changing during BUSY_A; the raised write is served afterwards.
        read_a = 1'b1; address_a = 32'h0000_0060;
        serve(2, 32'h0000_1234, 1'b0, 1'b1, wb);
        chk("inject.winner", {31'd0, wb}, 32'd0);
        serve(1, 32'h5555_aaaa, 1'b0, 1'b0, wb);
        chk("inject.follow_b", {31'd0, wb}, 32'd1);

        // Contention from reset with both reads held continuously.
        rst = 1'b1;
        model_reset();
        tick;
        rst = 1'b0;
        read_a = 1'b1; address_a = 32'h0000_0010;
        read_b = 1'b1; address_b = 32'h0000_0020; wmask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            serve(1 + i, 32'h0c00_0000 + 32'(i), 1'b1, 1'b0, wb);
            order[i] = wb;
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
`else
        exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1; exp_order[3] = 1;
`endif
        for (int i = 0; i < 4; i++) begin
            chk("contention.order", {31'd0, order[i]}, {31'd0, exp_order[i]});
        end
        read_a = 1'b0; read_b = 1'b0;

        // Asynchronous reset in the middle of a BUSY_B cycle.
        read_b = 1'b1; address_b = 32'h0000_0300;
        tick;
        chk("rst_busy.mem_read", {31'd0, mem_read}, 32'd1);
        #3;
        rst = 1'b1;
        read_b = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick;
        mem_resp = 1'b1; mem_rdata = 32'h0000_0bad;
        tick;
        chk_quiet("late_resp");
        mem_resp = 1'b0;
        read_a = 1'b1; address_a = 32'h0000_0044;
        serve(2, 32'h0000_abcd, 1'b0, 1'b0, wb);
        chk("post_reset.winner", {31'd0, wb}, 32'd0);

        // Randomised traffic against the model.
        for (int it = 0; it < 60; it++) begin
            if (!read_a && $urandom_range(0, 1) == 1) begin
                read_a = 1'b1; address_a = $urandom;
            end
            if (!(read_b | write) && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: begin read_b = 1'b1; write = 1'b0; end
                    1: begin read_b = 1'b0; write = 1'b1; end
                    default: begin read_b = 1'b1; write = 1'b1; end
                endcase
                address_b = $urandom; wdata = $urandom; wmask = 4'($urandom);
            end
            if (!(read_a | read_b | write)) begin
                mem_resp = 1'($urandom);
                tick;
                mem_resp = 1'b0;
                chk_quiet("rand_idle");
            end else begin
                serve(int'($urandom_range(1, 4)), $urandom, 1'b0, 1'b0, wb);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
